// File: rtl/npu_fsm_pkg.sv
// rtl/npu_fsm_pkg.sv - shared state encoding and defaults for the NPU load/store sequencers
package npu_fsm_pkg;

  // Words moved per load/store; the output sequencer uses the same default.
  localparam int NUM_WORDS_DEF = 8;

  // Input-sequencer state encoding.
  typedef enum logic [1:0] {
    IN_IDLE  = 2'd0,
    IN_ISSUE = 2'd1,
    IN_DRAIN = 2'd2,
    IN_DONE  = 2'd3
  } in_state_e;

endpackage

// File: rtl/lat_pipe.sv
// rtl/lat_pipe.sv - holdable single-bit delay line modelling memory read latency
module lat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  // Shift one stage per enabled cycle; hold everything while en_i is low.
  always_comb begin
    pipe_d = pipe_q;
    if (en_i) begin
      pipe_d[0] = d_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  // Stage registers; clearing them drops any data still in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fsm_in.sv
// rtl/fsm_in.sv - input-side load sequencer: issues NUM_WORDS reads and strobes the SIPO per returned word
module fsm_in
  import npu_fsm_pkg::*;
#(
  parameter int NUM_WORDS  = NUM_WORDS_DEF,
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic              SHIFT_IN,
  output logic              EN_SIPO_IN,
  output logic              IN_DONE,
  output logic              BUSY
);

  // State names are package-qualified because the IN_DONE port shadows the enum literal.
  localparam int              CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

  in_state_e         state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  shift_cnt_q, shift_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              shift;

  // RD_EN delayed by the read latency marks the cycle the word is on the bus.
  lat_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_lat_pipe (
    .clk_i (clk),
    .rst_ni(reset),
    .en_i  (enable),
    .d_i   (RD_EN),
    .q_o   (shift)
  );

  // Next-state, counter and address update; shifts may land during ISSUE or DRAIN.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    shift_cnt_d = shift_cnt_q;
    addr_d      = addr_q;
    if (shift) begin
      shift_cnt_d = (shift_cnt_q == LAST) ? '0 : shift_cnt_q + 1'b1;
    end
    case (state_q)
      npu_fsm_pkg::IN_IDLE: begin
        if (start) begin
          state_d     = npu_fsm_pkg::IN_ISSUE;
          addr_d      = base_addr;
          issue_cnt_d = '0;
          shift_cnt_d = '0;
        end
      end
      npu_fsm_pkg::IN_ISSUE: begin
        addr_d = addr_q + 1'b1;
        if (issue_cnt_q == LAST) begin
          state_d     = npu_fsm_pkg::IN_DRAIN;
          issue_cnt_d = '0;
        end else begin
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
      end
      npu_fsm_pkg::IN_DRAIN: begin
        if (shift && (shift_cnt_q == LAST)) begin
          state_d = npu_fsm_pkg::IN_DONE;
        end
      end
      npu_fsm_pkg::IN_DONE: begin
        state_d = npu_fsm_pkg::IN_IDLE;
      end
      default: begin
        state_d = npu_fsm_pkg::IN_IDLE;
      end
    endcase
  end

  // State and counters advance only on enabled edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= npu_fsm_pkg::IN_IDLE;
      issue_cnt_q <= '0;
      shift_cnt_q <= '0;
      addr_q      <= '0;
    end else if (enable) begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      addr_q      <= addr_d;
    end
  end

  assign RD_EN      = (state_q == npu_fsm_pkg::IN_ISSUE);
  assign RD_ADDR    = addr_q;
  assign SHIFT_IN   = shift;
  assign EN_SIPO_IN = (state_q == npu_fsm_pkg::IN_ISSUE) || (state_q == npu_fsm_pkg::IN_DRAIN);
  assign IN_DONE    = (state_q == npu_fsm_pkg::IN_DONE);
  assign BUSY       = (state_q != npu_fsm_pkg::IN_IDLE);

endmodule
